// File: rtl/alu_exec_unit.sv
// Multi-cycle execute-stage ALU feeding the CPU flag register file.
// Single-cycle ops finish on the start edge; SHL shifts one bit per cycle
// and MUL runs a WIDTH-step shift-add. Result and flags update only on the
// edge that raises done.
module alu_exec_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_we,
    output logic             flag_we,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     work;      // SHL working register
    logic [SHW-1:0]       cnt;       // SHL: shifts remaining; MUL: iterations done
    logic [2*WIDTH-1:0]   acc;       // MUL partial product
    logic [2*WIDTH-1:0]   mcand;     // MUL multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplier;    // MUL multiplier, shifted right each step

    logic [WIDTH:0]       add_sum, sub_sum;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [SHW-1:0]       shamt;

    // Completion bundle: asserted in the cycle whose closing edge raises done.
    logic                 fin, fin_res_we, fin_c, fin_v;
    logic [WIDTH-1:0]     fin_res;

    assign busy    = (state != IDLE);
    assign shamt   = b[SHW-1:0];
    assign add_sum = {1'b0, a} + {1'b0, b};
    // Subtraction as a + ~b + 1 so carry-out means "no borrow".
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and completion decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned (which would infer a latch).
        state_next = state;
        fin        = 1'b0;
        fin_res_we = 1'b0;
        fin_res    = '0;
        fin_c      = 1'b0;
        fin_v      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    fin        = 1'b1;
                    fin_res_we = 1'b1;
                    unique case (op)
                        OP_ADD: begin
                            fin_res = add_sum[WIDTH-1:0];
                            fin_c   = add_sum[WIDTH];
                            fin_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                      (add_sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB, OP_CMP: begin
                            fin_res    = sub_sum[WIDTH-1:0];
                            fin_c      = sub_sum[WIDTH];
                            fin_v      = (a[WIDTH-1] != b[WIDTH-1]) &&
                                         (sub_sum[WIDTH-1] != a[WIDTH-1]);
                            fin_res_we = (op == OP_SUB);
                        end
                        OP_AND: fin_res = a & b;
                        OP_OR:  fin_res = a | b;
                        OP_XOR: fin_res = a ^ b;
                        OP_SHL: begin
                            fin_res = a;
                            if (shamt != '0) begin
                                fin        = 1'b0;
                                fin_res_we = 1'b0;
                                state_next = SHIFT;
                            end
                        end
                        OP_MUL: begin
                            fin        = 1'b0;
                            fin_res_we = 1'b0;
                            state_next = MUL;
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                // Final shift: the bit leaving the MSB becomes carry.
                fin_res = {work[WIDTH-2:0], 1'b0};
                fin_c   = work[WIDTH-1];
                if (cnt == SHW'(1)) begin
                    fin        = 1'b1;
                    fin_res_we = 1'b1;
                    state_next = IDLE;
                end
            end
            MUL: begin
                fin_res = acc_sum[WIDTH-1:0];
                fin_c   = |acc_sum[2*WIDTH-1:WIDTH];
                if (cnt == SHW'(WIDTH - 1)) begin
                    fin        = 1'b1;
                    fin_res_we = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and iterative datapath (shift register, shift-add).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work   <= a;
                        cnt    <= (op == OP_SHL) ? shamt : '0;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                    end
                end
                SHIFT: begin
                    work <= {work[WIDTH-2:0], 1'b0};
                    cnt  <= cnt - SHW'(1);
                end
                MUL: begin
                    acc    <= acc_sum;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt + SHW'(1);
                end
                default: ;
            endcase
        end
    end

    // Completion pulses and held result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            flag_we   <= 1'b0;
            result_we <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done      <= fin;
            flag_we   <= fin;
            result_we <= fin && fin_res_we;
            if (fin) begin
                carry    <= fin_c;
                overflow <= fin_v;
                negative <= fin_res[WIDTH-1];
                zero     <= (fin_res == '0);
                if (fin_res_we) result <= fin_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=8).
module tb_alu_exec_unit;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, CMP = 3'b101,
                           SHL = 3'b110, MUL = 3'b111, AND_ = 3'b010;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       busy, done, result_we, flag_we, carry, overflow, negative, zero;
    logic [7:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .result_we(result_we),
        .flag_we(flag_we), .carry(carry), .overflow(overflow),
        .negative(negative), .zero(zero)
    );

    always #5 clk = ~clk;

    // Launch one op on the next rising edge, then wait (bounded) for done.
    // lat = edges after the start edge until done is visible.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Compare flags CVNZ as a 4-bit vector plus result.
    task automatic cmp_out(input string name, input logic [7:0] er, input logic [3:0] ef);
        n_cmp++;
        if (result !== er) begin
            n_bad++;
            $display("FAIL %s result: got %h want %h", name, result, er);
        end
        n_cmp++;
        if ({carry, overflow, negative, zero} !== ef) begin
            n_bad++;
            $display("FAIL %s CVNZ: got %b want %b", name, {carry, overflow, negative, zero}, ef);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, result_we, flag_we, carry, overflow, negative, zero, result} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset outputs: got %b want all zero",
                     {busy, done, result_we, flag_we, carry, overflow, negative, zero, result});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add;
        int lat, bc;
        run_op(ADD, 8'h7F, 8'h01, lat, bc);
        n_cmp++;
        if (lat !== 0) begin n_bad++; $display("FAIL add latency: got %0d want 0", lat); end
        cmp_out("add", 8'h80, 4'b0110);
        n_cmp++;
        if ({done, flag_we, result_we} !== 3'b111) begin
            n_bad++; $display("FAIL add pulses: got %b want 111", {done, flag_we, result_we});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, flag_we, result_we} !== 3'b000) begin
            n_bad++; $display("FAIL add pulse clear: got %b want 000", {done, flag_we, result_we});
        end
        cmp_out("add hold", 8'h80, 4'b0110);
    endtask

    task automatic test_sub_cmp;
        int lat, bc;
        run_op(SUB, 8'h05, 8'h05, lat, bc);
        cmp_out("sub", 8'h00, 4'b1001);
        run_op(CMP, 8'h03, 8'h05, lat, bc);
        cmp_out("cmp", 8'h00, 4'b0010);
        n_cmp++;
        if ({done, flag_we, result_we} !== 3'b110) begin
            n_bad++; $display("FAIL cmp pulses: got %b want 110", {done, flag_we, result_we});
        end
        // Signed overflow on subtract: 0x80 - 0x01 = 0x7F, V=1, C=1.
        run_op(SUB, 8'h80, 8'h01, lat, bc);
        cmp_out("sub ovf", 8'h7F, 4'b1100);
        run_op(AND_, 8'hF0, 8'h3C, lat, bc);
        cmp_out("and", 8'h30, 4'b0000);
    endtask

    task automatic test_shl;
        int lat, bc;
        run_op(SHL, 8'hA1, 8'h03, lat, bc);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL shl latency: got %0d want 3", lat); end
        n_cmp++;
        if (bc !== 3) begin n_bad++; $display("FAIL shl busy cycles: got %0d want 3", bc); end
        cmp_out("shl3", 8'h08, 4'b1000);
        run_op(SHL, 8'hA1, 8'h00, lat, bc);
        n_cmp++;
        if (lat !== 0) begin n_bad++; $display("FAIL shl0 latency: got %0d want 0", lat); end
        cmp_out("shl0", 8'hA1, 4'b0010);
        // Maximum shift: 0x81 << 7 = 0x80, last bit out = 0.
        run_op(SHL, 8'h81, 8'h0F, lat, bc);
        n_cmp++;
        if (lat !== 7) begin n_bad++; $display("FAIL shl7 latency: got %0d want 7", lat); end
        cmp_out("shl7", 8'h80, 4'b0010);
    endtask

    task automatic test_mul;
        int lat, bc;
        run_op(MUL, 8'h10, 8'h20, lat, bc);
        n_cmp++;
        if (lat !== 8) begin n_bad++; $display("FAIL mul latency: got %0d want 8", lat); end
        cmp_out("mul 10x20", 8'h00, 4'b1001);
        run_op(MUL, 8'hFF, 8'hFF, lat, bc);
        cmp_out("mul FFxFF", 8'h01, 4'b1000);
    endtask

    // MUL with an ignored start mid-flight, then ADD launched in the done cycle.
    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        op = MUL; a = 8'h0F; b = 8'h0F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        op = ADD; a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat !== 8) begin n_bad++; $display("FAIL mul ignore latency: got %0d want 8", lat); end
        cmp_out("mul 0Fx0F", 8'hE1, 4'b0010);
        op = ADD; a = 8'h7F; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL b2b done: got %b want 1", done); end
        cmp_out("b2b add", 8'h80, 4'b0110);
    endtask

    task automatic test_reset_mid_mul;
        int lat, bc, seen;
        @(negedge clk);
        op = MUL; a = 8'h0F; b = 8'h0F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset-mid busy: got %b want 0", busy); end
        cmp_out("reset-mid", 8'h00, 4'b0000);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done) seen++; end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL reset-mid stray done: got %0d want 0", seen); end
        run_op(ADD, 8'h01, 8'h01, lat, bc);
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL post-reset add done: got %b want 1", done); end
        cmp_out("post-reset add", 8'h02, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_shl();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
